// File: rtl/redmule_stream_addressgen.sv
// Streamer address generator: takes one job per start request and emits tot_len byte
// addresses over a valid/ready port, walking up to three nested strided dimensions.
module redmule_stream_addressgen #(
    parameter int unsigned AW  = 32,
    parameter int unsigned TLW = 32,
    parameter int unsigned DLW = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           clear_i,
    input  logic           req_start_i,
    input  logic [AW-1:0]  base_addr_i,
    input  logic [TLW-1:0] tot_len_i,
    input  logic [DLW-1:0] d0_len_i,
    input  logic [AW-1:0]  d0_stride_i,
    input  logic [DLW-1:0] d1_len_i,
    input  logic [AW-1:0]  d1_stride_i,
    input  logic [AW-1:0]  d2_stride_i,
    input  logic [1:0]     dim_enable_1h_i,
    output logic           ready_start_o,
    output logic           done_o,
    output logic [AW-1:0]  addr_o,
    output logic           addr_valid_o,
    input  logic           addr_ready_i,
    output logic           addr_last_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  base_q, base_d;
    logic [TLW-1:0] tot_len_q, tot_len_d;
    logic [DLW-1:0] d0_len_q, d0_len_d;
    logic [DLW-1:0] d1_len_q, d1_len_d;
    logic [AW-1:0]  d0_stride_q, d0_stride_d;
    logic [AW-1:0]  d1_stride_q, d1_stride_d;
    logic [AW-1:0]  d2_stride_q, d2_stride_d;
    logic [1:0]     dim_en_q, dim_en_d;
    logic [DLW-1:0] d0_cnt_q, d0_cnt_d;
    logic [DLW-1:0] d1_cnt_q, d1_cnt_d;
    logic [AW-1:0]  d0_offs_q, d0_offs_d;
    logic [AW-1:0]  d1_offs_q, d1_offs_d;
    logic [AW-1:0]  d2_offs_q, d2_offs_d;
    logic [TLW-1:0] issued_q, issued_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           is_last;

    // The address on the port is the one about to be accepted as the issued_q-th.
    assign is_last       = (state_q == RUN) && (issued_q == tot_len_q - TLW'(1));
    assign ready_start_o = (state_q == IDLE);
    assign done_o        = (state_q == DONE);
    assign addr_valid_o  = (state_q == RUN);
    assign addr_last_o   = is_last;
    assign addr_o        = addr_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        tot_len_d   = tot_len_q;
        d0_len_d    = d0_len_q;
        d1_len_d    = d1_len_q;
        d0_stride_d = d0_stride_q;
        d1_stride_d = d1_stride_q;
        d2_stride_d = d2_stride_q;
        dim_en_d    = dim_en_q;
        d0_cnt_d    = d0_cnt_q;
        d1_cnt_d    = d1_cnt_q;
        d0_offs_d   = d0_offs_q;
        d1_offs_d   = d1_offs_q;
        d2_offs_d   = d2_offs_q;
        issued_d    = issued_q;
        addr_d      = addr_q;

        if (clear_i) begin
            state_d     = IDLE;
            base_d      = '0;
            tot_len_d   = '0;
            d0_len_d    = '0;
            d1_len_d    = '0;
            d0_stride_d = '0;
            d1_stride_d = '0;
            d2_stride_d = '0;
            dim_en_d    = '0;
            d0_cnt_d    = '0;
            d1_cnt_d    = '0;
            d0_offs_d   = '0;
            d1_offs_d   = '0;
            d2_offs_d   = '0;
            issued_d    = '0;
            addr_d      = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_start_i) begin
                        base_d      = base_addr_i;
                        tot_len_d   = tot_len_i;
                        // A zero length would never match cnt==len-1; treat it as 1.
                        d0_len_d    = (d0_len_i == '0) ? DLW'(1) : d0_len_i;
                        d1_len_d    = (d1_len_i == '0) ? DLW'(1) : d1_len_i;
                        d0_stride_d = d0_stride_i;
                        d1_stride_d = d1_stride_i;
                        d2_stride_d = d2_stride_i;
                        dim_en_d    = dim_enable_1h_i;
                        d0_cnt_d    = '0;
                        d1_cnt_d    = '0;
                        d0_offs_d   = '0;
                        d1_offs_d   = '0;
                        d2_offs_d   = '0;
                        issued_d    = '0;
                        addr_d      = base_addr_i;
                        state_d     = (tot_len_i == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (addr_ready_i) begin
                        issued_d  = issued_q + TLW'(1);
                        d0_cnt_d  = d0_cnt_q + DLW'(1);
                        d0_offs_d = d0_offs_q + d0_stride_q;
                        if (dim_en_q[0] && (d0_cnt_q == d0_len_q - DLW'(1))) begin
                            d0_cnt_d  = '0;
                            d0_offs_d = '0;
                            d1_cnt_d  = d1_cnt_q + DLW'(1);
                            d1_offs_d = d1_offs_q + d1_stride_q;
                            if (dim_en_q[1] && (d1_cnt_q == d1_len_q - DLW'(1))) begin
                                d1_cnt_d  = '0;
                                d1_offs_d = '0;
                                d2_offs_d = d2_offs_q + d2_stride_q;
                            end
                        end
                        addr_d = base_q + d0_offs_d + d1_offs_d + d2_offs_d;
                        if (is_last) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            base_q      <= '0;
            tot_len_q   <= '0;
            d0_len_q    <= '0;
            d1_len_q    <= '0;
            d0_stride_q <= '0;
            d1_stride_q <= '0;
            d2_stride_q <= '0;
            dim_en_q    <= '0;
            d0_cnt_q    <= '0;
            d1_cnt_q    <= '0;
            d0_offs_q   <= '0;
            d1_offs_q   <= '0;
            d2_offs_q   <= '0;
            issued_q    <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            tot_len_q   <= tot_len_d;
            d0_len_q    <= d0_len_d;
            d1_len_q    <= d1_len_d;
            d0_stride_q <= d0_stride_d;
            d1_stride_q <= d1_stride_d;
            d2_stride_q <= d2_stride_d;
            dim_en_q    <= dim_en_d;
            d0_cnt_q    <= d0_cnt_d;
            d1_cnt_q    <= d1_cnt_d;
            d0_offs_q   <= d0_offs_d;
            d1_offs_q   <= d1_offs_d;
            d2_offs_q   <= d2_offs_d;
            issued_q    <= issued_d;
            addr_q      <= addr_d;
        end
    end

endmodule

// File: tb/tb_redmule_stream_addressgen.sv
// Bench for redmule_stream_addressgen: directed job table, stall/clear/ignore sequences,
// and random jobs checked against an index-arithmetic address model.
module tb_redmule_stream_addressgen;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        req_start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [31:0] tot_len_i = '0;
    logic [15:0] d0_len_i = '0;
    logic [31:0] d0_stride_i = '0;
    logic [15:0] d1_len_i = '0;
    logic [31:0] d1_stride_i = '0;
    logic [31:0] d2_stride_i = '0;
    logic [1:0]  dim_enable_1h_i = '0;
    logic        ready_start_o;
    logic        done_o;
    logic [31:0] addr_o;
    logic        addr_valid_o;
    logic        addr_ready_i = 1'b0;
    logic        addr_last_o;

    redmule_stream_addressgen #(.AW(32), .TLW(32), .DLW(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .req_start_i(req_start_i),
        .base_addr_i(base_addr_i), .tot_len_i(tot_len_i), .d0_len_i(d0_len_i),
        .d0_stride_i(d0_stride_i), .d1_len_i(d1_len_i), .d1_stride_i(d1_stride_i),
        .d2_stride_i(d2_stride_i), .dim_enable_1h_i(dim_enable_1h_i),
        .ready_start_o(ready_start_o), .done_o(done_o), .addr_o(addr_o),
        .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready_i), .addr_last_o(addr_last_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] base;
        logic [31:0] tot;
        logic [15:0] l0;
        logic [31:0] s0;
        logic [15:0] l1;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [1:0]  en;
        bit          poke;
        logic [31:0] exp [8];
    } job_t;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Reference: address from the multi-dimensional index of the k-th element.
    function automatic void model(input job_t j);
        int unsigned l0, l1, i0, i1, i2;
        exp_q.delete();
        l0 = (j.l0 == 0) ? 1 : j.l0;
        l1 = (j.l1 == 0) ? 1 : j.l1;
        for (int unsigned k = 0; k < j.tot; k++) begin
            if (!j.en[0]) begin
                i0 = k; i1 = 0; i2 = 0;
            end else if (!j.en[1]) begin
                i0 = k % l0; i1 = k / l0; i2 = 0;
            end else begin
                i0 = k % l0; i1 = (k / l0) % l1; i2 = k / (l0 * l1);
            end
            exp_q.push_back(j.base + i0 * j.s0 + i1 * j.s1 + i2 * j.s2);
        end
    endfunction

    // mode 0: ready always high; 1: stall 3 cycles on 2nd address; 2: random ready.
    task automatic run_job(input job_t j, input int mode);
        int idx = 0, stall = 0, budget = 0;
        bit rdy;
        base_addr_i = j.base; tot_len_i = j.tot; d0_len_i = j.l0; d0_stride_i = j.s0;
        d1_len_i = j.l1; d1_stride_i = j.s1; d2_stride_i = j.s2; dim_enable_1h_i = j.en;
        req_start_i = 1'b1; addr_ready_i = 1'b0;
        @(negedge clk_i);
        req_start_i = 1'b0;
        if (j.tot != 0) chk("ready_start_busy", {31'd0, ready_start_o}, 32'd0);
        while (idx < int'(j.tot) && budget < 2000) begin
            budget++;
            chk("valid", {31'd0, addr_valid_o}, 32'd1);
            chk("addr", addr_o, exp_q[idx]);
            chk("last", {31'd0, addr_last_o}, {31'd0, idx == int'(j.tot) - 1});
            if (j.poke) begin
                req_start_i = 1'b1; base_addr_i = 32'hDEAD0000; tot_len_i = 32'd5;
            end
            case (mode)
                0: rdy = 1'b1;
                1: if (idx == 1 && stall < 3) begin rdy = 1'b0; stall++; end else rdy = 1'b1;
                default: rdy = ($urandom % 4) != 0;
            endcase
            addr_ready_i = rdy;
            if (rdy) idx++;
            @(negedge clk_i);
        end
        req_start_i = 1'b0; addr_ready_i = 1'b0;
        if (budget >= 2000) chk("job_timeout", 32'd1, 32'd0);
        chk("done_pulse", {31'd0, done_o}, 32'd1);
        chk("valid_after", {31'd0, addr_valid_o}, 32'd0);
        @(negedge clk_i);
        chk("done_end", {31'd0, done_o}, 32'd0);
        chk("ready_start_back", {31'd0, ready_start_o}, 32'd1);
        $display("job base=%h tot=%0d en=%b mode=%0d handshakes=%0d", j.base, j.tot, j.en, mode, idx);
    endtask

    job_t tab [4];
    job_t j;

    initial begin
        tab[0] = '{base:32'h1000, tot:4, l0:1, s0:0, l1:4, s1:32'h40, s2:0, en:2'b11, poke:0,
                   exp:'{32'h1000, 32'h1040, 32'h1080, 32'h10C0, 0, 0, 0, 0}};
        tab[1] = '{base:0, tot:8, l0:2, s0:4, l1:2, s1:32'h100, s2:32'h1000, en:2'b11, poke:0,
                   exp:'{0, 4, 32'h100, 32'h104, 32'h1000, 32'h1004, 32'h1100, 32'h1104}};
        tab[2] = '{base:32'hFFFFFFF0, tot:2, l0:1, s0:0, l1:2, s1:32'h10, s2:0, en:2'b11, poke:1,
                   exp:'{32'hFFFFFFF0, 32'h0, 0, 0, 0, 0, 0, 0}};
        tab[3] = '{base:32'h2000, tot:0, l0:1, s0:0, l1:1, s1:0, s2:0, en:2'b11, poke:0,
                   exp:'{0, 0, 0, 0, 0, 0, 0, 0}};

        repeat (3) @(negedge clk_i);
        chk("rst_ready_start", {31'd0, ready_start_o}, 32'd1);
        chk("rst_valid", {31'd0, addr_valid_o}, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_addr", addr_o, 32'd0);
        chk("rst_last", {31'd0, addr_last_o}, 32'd0);

        for (int t = 0; t < 4; t++) begin
            exp_q.delete();
            for (int k = 0; k < int'(tab[t].tot); k++) exp_q.push_back(tab[t].exp[k]);
            run_job(tab[t], 0);
        end

        // Backpressure on the second address.
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(tab[0].exp[k]);
        run_job(tab[0], 1);

        // Clear after two handshakes aborts silently, then a restart begins from base.
        j = tab[0];
        base_addr_i = j.base; tot_len_i = j.tot; d0_len_i = j.l0; d0_stride_i = j.s0;
        d1_len_i = j.l1; d1_stride_i = j.s1; d2_stride_i = j.s2; dim_enable_1h_i = j.en;
        req_start_i = 1'b1;
        @(negedge clk_i);
        req_start_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("clr_addr", addr_o, j.exp[k]);
            addr_ready_i = 1'b1;
            @(negedge clk_i);
        end
        clear_i = 1'b1; req_start_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0; req_start_i = 1'b0; addr_ready_i = 1'b0;
        chk("clr_valid", {31'd0, addr_valid_o}, 32'd0);
        chk("clr_ready_start", {31'd0, ready_start_o}, 32'd1);
        chk("clr_done", {31'd0, done_o}, 32'd0);
        chk("clr_addr0", addr_o, 32'd0);
        @(negedge clk_i);
        chk("clr_no_done", {31'd0, done_o}, 32'd0);
        chk("clr_no_accept", {31'd0, addr_valid_o}, 32'd0);
        $display("clear sequence done");
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(tab[0].exp[k]);
        run_job(tab[0], 0);

        // Randomised jobs against the index model.
        for (int r = 0; r < 30; r++) begin
            j.base = $urandom;
            j.tot  = $urandom_range(0, 40);
            j.l0   = 16'($urandom_range(0, 4));
            j.l1   = 16'($urandom_range(0, 4));
            j.s0   = $urandom;
            j.s1   = $urandom;
            j.s2   = $urandom;
            j.en   = 2'($urandom);
            j.poke = 0;
            model(j);
            run_job(j, 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
